// File: rtl/dphy_rx_pkg.sv
// rtl/dphy_rx_pkg.sv - shared state type and constants for the D-PHY RX byte aligner
package dphy_rx_pkg;

  localparam logic [7:0] DPHY_SYNC_BYTE = 8'hB8;
  localparam int         DPHY_OFF_W     = 3;

  typedef enum logic [1:0] {
    IDLE,
    HUNT,
    LOCKED,
    FLUSH
  } dphy_rx_state_t;

  function automatic logic [3:0] popcount8(input logic [7:0] v);
    logic [3:0] n;
    n = '0;
    for (int i = 0; i < 8; i++) begin
      n = n + {3'b000, v[i]};
    end
    return n;
  endfunction

endpackage

// File: rtl/dphy_sync_match.sv
// rtl/dphy_sync_match.sv - combinational 8-offset SoT sync matcher (DPHY_RX_SOT_TOLERANT_EN adds 1-bit-error hits)
module dphy_sync_match
  import dphy_rx_pkg::*;
#(
  parameter logic [7:0] SYNC_BYTE = DPHY_SYNC_BYTE
) (
  input  logic [15:0]           window,
  output logic                  hit,
  output logic [DPHY_OFF_W-1:0] offset
`ifdef DPHY_RX_SOT_TOLERANT_EN
  ,
  output logic                  hit_1b
`endif
);

  logic [7:0]            cand [8];
  logic                  exact_hit;
  logic [DPHY_OFF_W-1:0] exact_off;

  for (genvar k = 0; k < 8; k++) begin : g_cand
    assign cand[k] = window[k +: 8];
  end

  // Scan from the top down so the lowest matching offset is the one left standing.
  always_comb begin
    exact_hit = 1'b0;
    exact_off = '0;
    for (int k = 7; k >= 0; k--) begin
      if (cand[k] == SYNC_BYTE) begin
        exact_hit = 1'b1;
        exact_off = DPHY_OFF_W'(k);
      end
    end
  end

`ifdef DPHY_RX_SOT_TOLERANT_EN
  logic                  near_hit;
  logic [DPHY_OFF_W-1:0] near_off;

  always_comb begin
    near_hit = 1'b0;
    near_off = '0;
    for (int k = 7; k >= 0; k--) begin
      if (popcount8(cand[k] ^ SYNC_BYTE) == 4'd1) begin
        near_hit = 1'b1;
        near_off = DPHY_OFF_W'(k);
      end
    end
  end

  // An exact match anywhere in the window outranks a corrupted leader.
  assign hit    = exact_hit | near_hit;
  assign offset = exact_hit ? exact_off : near_off;
  assign hit_1b = near_hit & ~exact_hit;
`else
  assign hit    = exact_hit;
  assign offset = exact_off;
`endif

endmodule

// File: rtl/dphy_rx_byte_align.sv
// rtl/dphy_rx_byte_align.sv - HS-mode byte aligner for one D-PHY RX lane (DPHY_RX_SOT_TOLERANT_EN adds sot_err)
module dphy_rx_byte_align
  import dphy_rx_pkg::*;
#(
  parameter logic [7:0] SYNC_BYTE = DPHY_SYNC_BYTE,
  parameter int         TIMEOUT   = 16
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  hs_en,
  input  logic [7:0]            raw_byte,
  input  logic                  raw_valid,
  output logic [7:0]            byte_out,
  output logic                  byte_valid,
  output logic                  sot,
  output logic                  eot,
  output logic                  sync_err,
  output logic                  locked,
  output logic [DPHY_OFF_W-1:0] bit_offset
`ifdef DPHY_RX_SOT_TOLERANT_EN
  ,
  output logic                  sot_err
`endif
);

  localparam logic [7:0] TIMEOUT_B = 8'(TIMEOUT);

  dphy_rx_state_t        state;
  dphy_rx_state_t        state_nx;
  logic [7:0]            prev;
  logic [7:0]            cnt;
  logic [7:0]            cnt_inc;
  logic [7:0]            aligned;
  logic [15:0]           window;
  logic                  first;
  logic                  beat;
  logic                  hit;
  logic [DPHY_OFF_W-1:0] hit_off;
  logic                  take;
  logic                  emit;
  logic                  eot_nx;
  logic                  err_nx;

  assign window  = {raw_byte, prev};
  assign beat    = raw_valid & hs_en;
  assign cnt_inc = (cnt == 8'hFF) ? cnt : cnt + 8'd1;
  assign aligned = window[bit_offset +: 8];
  assign locked  = (state == LOCKED);

`ifdef DPHY_RX_SOT_TOLERANT_EN
  logic hit_1b;

  dphy_sync_match #(
    .SYNC_BYTE(SYNC_BYTE)
  ) u_match (
    .window(window),
    .hit   (hit),
    .offset(hit_off),
    .hit_1b(hit_1b)
  );
`else
  dphy_sync_match #(
    .SYNC_BYTE(SYNC_BYTE)
  ) u_match (
    .window(window),
    .hit   (hit),
    .offset(hit_off)
  );
`endif

  // Dropping hs_en wins over everything, including a beat in the same cycle.
  always_comb begin
    state_nx = state;
    take     = 1'b0;
    emit     = 1'b0;
    eot_nx   = 1'b0;
    err_nx   = 1'b0;
    case (state)
      IDLE: begin
        if (hs_en) begin
          state_nx = HUNT;
        end
      end
      HUNT: begin
        if (!hs_en) begin
          state_nx = IDLE;
        end else if (raw_valid) begin
          if (hit) begin
            take     = 1'b1;
            state_nx = LOCKED;
          end else if (cnt_inc >= TIMEOUT_B) begin
            err_nx   = 1'b1;
            state_nx = FLUSH;
          end
        end
      end
      LOCKED: begin
        if (!hs_en) begin
          eot_nx   = 1'b1;
          state_nx = IDLE;
        end else if (raw_valid) begin
          emit = 1'b1;
        end
      end
      FLUSH: begin
        if (!hs_en) begin
          state_nx = IDLE;
        end
      end
      default: state_nx = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state      <= IDLE;
      prev       <= 8'h00;
      cnt        <= 8'h00;
      first      <= 1'b0;
      byte_out   <= 8'h00;
      byte_valid <= 1'b0;
      sot        <= 1'b0;
      eot        <= 1'b0;
      sync_err   <= 1'b0;
      bit_offset <= '0;
`ifdef DPHY_RX_SOT_TOLERANT_EN
      sot_err    <= 1'b0;
`endif
    end else begin
      state      <= state_nx;
      byte_valid <= emit;
      sot        <= emit & first;
      eot        <= eot_nx;
      sync_err   <= err_nx;
`ifdef DPHY_RX_SOT_TOLERANT_EN
      sot_err    <= take & hit_1b;
`endif

      if (state == IDLE) begin
        prev <= 8'h00;
      end else if (beat) begin
        prev <= raw_byte;
      end

      // Only misses in HUNT accumulate; any exit from HUNT restarts the count.
      if (state_nx != HUNT) begin
        cnt <= 8'h00;
      end else if (beat) begin
        cnt <= cnt_inc;
      end

      if (take) begin
        bit_offset <= hit_off;
        first      <= 1'b1;
      end else if (emit) begin
        first      <= 1'b0;
      end

      if (emit) begin
        byte_out <= aligned;
      end
    end
  end

endmodule

// File: tb/tb_dphy_rx_byte_align.sv
// tb/tb_dphy_rx_byte_align.sv - randomized self-checking bench against a bit-stream reference model
module tb_dphy_rx_byte_align;

  localparam logic [7:0] SYNC    = 8'hB8;
  localparam int         TIMEOUT = 16;
`ifdef DPHY_RX_SOT_TOLERANT_EN
  localparam bit TOL = 1'b1;
`else
  localparam bit TOL = 1'b0;
`endif

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic       hs_en = 1'b0;
  logic [7:0] raw_byte = 8'h00;
  logic       raw_valid = 1'b0;
  logic [7:0] byte_out;
  logic       byte_valid;
  logic       sot;
  logic       eot;
  logic       sync_err;
  logic       locked;
  logic [2:0] bit_offset;
`ifdef DPHY_RX_SOT_TOLERANT_EN
  logic       sot_err;
`endif

  always #5 clk = ~clk;

  dphy_rx_byte_align #(
    .SYNC_BYTE(SYNC),
    .TIMEOUT  (TIMEOUT)
  ) dut (
    .clk       (clk),
    .reset     (reset),
    .hs_en     (hs_en),
    .raw_byte  (raw_byte),
    .raw_valid (raw_valid),
    .byte_out  (byte_out),
    .byte_valid(byte_valid),
    .sot       (sot),
    .eot       (eot),
    .sync_err  (sync_err),
    .locked    (locked),
`ifdef DPHY_RX_SOT_TOLERANT_EN
    .sot_err   (sot_err),
`endif
    .bit_offset(bit_offset)
  );

  int checks = 0;
  int errors = 0;

  logic [8:0] out_q[$];
  int         eot_cnt;
  int         serr_cnt;
  int         soterr_cnt;

  logic [7:0] stim_q[$];
  logic [7:0] exp_q[$];
  bit         m_found;
  bit         m_serr;
  bit         m_near;
  int         m_off;

  always @(negedge clk) begin
    if (byte_valid) out_q.push_back({sot, byte_out});
    if (eot) eot_cnt++;
    if (sync_err) serr_cnt++;
`ifdef DPHY_RX_SOT_TOLERANT_EN
    if (sot_err) soterr_cnt++;
`endif
  end

  task automatic clear_mon();
    out_q.delete();
    eot_cnt    = 0;
    serr_cnt   = 0;
    soterr_cnt = 0;
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic beat(input logic [7:0] b);
    raw_valid = 1'b1;
    raw_byte  = b;
    step();
    raw_valid = 1'b0;
  endtask

  // Reference: the burst is a bit stream preceded by 8 zero bits; each beat exposes
  // bit positions 8j..8j+7 as leader start points, scanned in order.
  task automatic model_run();
    logic [8*72-1:0] s;
    int n;
    int misses;
    int sj;
    int p;
    s = '0;
    n = stim_q.size();
    for (int j = 0; j < n; j++) s[8*(j+1) +: 8] = stim_q[j];
    m_found = 1'b0;
    m_serr  = 1'b0;
    m_near  = 1'b0;
    m_off   = 0;
    misses  = 0;
    sj      = 0;
    p       = 0;
    exp_q.delete();
    for (int j = 0; j < n; j++) begin
      if (!m_found && !m_serr) begin
        int best;
        best = -1;
        for (int k = 0; k < 8; k++)
          if (best < 0 && s[8*j+k +: 8] == SYNC) best = k;
        if (TOL && best < 0) begin
          for (int k = 0; k < 8; k++)
            if (best < 0 && $countones(s[8*j+k +: 8] ^ SYNC) == 1) begin
              best   = k;
              m_near = 1'b1;
            end
        end
        if (best >= 0) begin
          m_found = 1'b1;
          m_off   = best;
          sj      = j;
          p       = 8*j + best;
        end else begin
          misses++;
          if (misses == TIMEOUT) m_serr = 1'b1;
        end
      end
    end
    if (m_found)
      for (int j = sj + 1; j < n; j++) exp_q.push_back(s[p + 8 + 8*(j-sj-1) +: 8]);
  endtask

  task automatic make_burst(input int pl);
    logic [8*40-1:0] s;
    int m;
    int o;
    int n;
    m = $urandom_range(0, 3);
    o = $urandom_range(0, 7);
    n = m + 1 + pl;
    s = '0;
    for (int i = 0; i < n; i++) s[8*i +: 8] = 8'($urandom);
    s[8*m + o +: 8] = SYNC;
    stim_q.delete();
    for (int i = 0; i < n; i++) stim_q.push_back(s[8*i +: 8]);
  endtask

  task automatic run_burst(input bit gaps, input bit junk_on_fall);
    clear_mon();
    hs_en     = 1'b1;
    raw_valid = 1'b0;
    step();
    foreach (stim_q[i]) begin
      if (gaps) repeat ($urandom_range(0, 2)) step();
      beat(stim_q[i]);
    end
    raw_valid = junk_on_fall;
    raw_byte  = 8'($urandom);
    hs_en     = 1'b0;
    step();
    raw_valid = 1'b0;
    repeat (3) step();
  endtask

  task automatic test_reset();
    repeat (3) step();
    checks++;
    if ({byte_out, byte_valid, sot, eot, sync_err, locked, bit_offset} !== 16'h0) begin
      errors++;
      $display("FAIL reset_outputs got %h want 0", {byte_out, byte_valid, sot, eot, sync_err, locked, bit_offset});
    end
    reset = 1'b0;
    clear_mon();
    repeat (2) step();
    checks++;
    if (locked !== 1'b0 || out_q.size() != 0) begin
      errors++;
      $display("FAIL reset_idle locked %b bytes %0d want 0 0", locked, out_q.size());
    end
  endtask

  task automatic test_offset0();
    clear_mon();
    hs_en = 1'b1;
    step();
    beat(8'hB8);
    checks++;
    if (locked !== 1'b0) begin
      errors++;
      $display("FAIL off0_early_lock locked %b want 0", locked);
    end
    beat(8'h55);
    checks++;
    if (locked !== 1'b1 || bit_offset !== 3'd0) begin
      errors++;
      $display("FAIL off0_lock locked %b off %0d want 1 0", locked, bit_offset);
    end
    beat(8'hAA);
    beat(8'h00);
    hs_en = 1'b0;
    repeat (3) step();
    checks++;
    if (out_q.size() != 2) begin
      errors++;
      $display("FAIL off0_count got %0d want 2", out_q.size());
    end else begin
      checks++;
      if (out_q[0] !== 9'h155 || out_q[1] !== 9'h0AA) begin
        errors++;
        $display("FAIL off0_bytes got %h %h want 155 0aa", out_q[0], out_q[1]);
      end
    end
    checks++;
    if (eot_cnt != 1 || locked !== 1'b0) begin
      errors++;
      $display("FAIL off0_eot eot %0d locked %b want 1 0", eot_cnt, locked);
    end
  endtask

  task automatic test_offset3();
    logic [7:0] d[4];
    logic [7:0] pv;
    clear_mon();
    for (int i = 0; i < 4; i++) d[i] = 8'($urandom);
    hs_en = 1'b1;
    step();
    beat(8'hC0);
    beat(8'h05);
    checks++;
    if (locked !== 1'b1 || bit_offset !== 3'd3) begin
      errors++;
      $display("FAIL off3_lock locked %b off %0d want 1 3", locked, bit_offset);
    end
    for (int i = 0; i < 4; i++) beat(d[i]);
    hs_en = 1'b0;
    repeat (3) step();
    checks++;
    if (out_q.size() != 4) begin
      errors++;
      $display("FAIL off3_count got %0d want 4", out_q.size());
    end else begin
      pv = 8'h05;
      for (int i = 0; i < 4; i++) begin
        logic [15:0] w;
        logic [8:0]  e;
        w = {d[i], pv};
        e = {(i == 0) ? 1'b1 : 1'b0, w[10:3]};
        pv = d[i];
        checks++;
        if (out_q[i] !== e) begin
          errors++;
          $display("FAIL off3_byte%0d got %h want %h", i, out_q[i], e);
        end
      end
    end
  endtask

  task automatic test_timeout();
    clear_mon();
    hs_en = 1'b1;
    step();
    repeat (TIMEOUT - 1) beat(8'h00);
    step();
    checks++;
    if (serr_cnt != 0) begin
      errors++;
      $display("FAIL timeout_early sync_err %0d want 0", serr_cnt);
    end
    beat(8'h00);
    step();
    checks++;
    if (serr_cnt != 1) begin
      errors++;
      $display("FAIL timeout_pulse sync_err %0d want 1", serr_cnt);
    end
    beat(8'hB8);
    beat(8'h55);
    beat(8'hAA);
    checks++;
    if (locked !== 1'b0) begin
      errors++;
      $display("FAIL flush_lock locked %b want 0", locked);
    end
    hs_en = 1'b0;
    repeat (3) step();
    checks++;
    if (out_q.size() != 0 || serr_cnt != 1 || eot_cnt != 0) begin
      errors++;
      $display("FAIL timeout_quiet bytes %0d serr %0d eot %0d want 0 1 0", out_q.size(), serr_cnt, eot_cnt);
    end
  endtask

  task automatic test_eot_gaps();
    make_burst($urandom_range(4, 12));
    model_run();
    run_burst(1'b1, 1'b1);
    checks++;
    if (out_q.size() != exp_q.size()) begin
      errors++;
      $display("FAIL gaps_count got %0d want %0d", out_q.size(), exp_q.size());
    end else begin
      foreach (exp_q[i]) begin
        logic [8:0] e;
        e = {(i == 0) ? 1'b1 : 1'b0, exp_q[i]};
        checks++;
        if (out_q[i] !== e) begin
          errors++;
          $display("FAIL gaps_byte%0d got %h want %h", i, out_q[i], e);
        end
      end
    end
    checks++;
    if (eot_cnt != 1 || locked !== 1'b0 || bit_offset !== 3'(m_off)) begin
      errors++;
      $display("FAIL gaps_end eot %0d locked %b off %0d want 1 0 %0d", eot_cnt, locked, bit_offset, m_off);
    end
  endtask

  task automatic test_reset_mid();
    clear_mon();
    hs_en = 1'b1;
    step();
    beat(8'hC0);
    beat(8'h05);
    beat(8'h11);
    raw_valid = 1'b1;
    raw_byte  = 8'h22;
    step();
    checks++;
    if (byte_valid !== 1'b1 || locked !== 1'b1) begin
      errors++;
      $display("FAIL rstmid_pre valid %b locked %b want 1 1", byte_valid, locked);
    end
    #2;
    reset = 1'b1;
    clear_mon();
    #1;
    checks++;
    if ({byte_out, byte_valid, sot, eot, sync_err, locked, bit_offset} !== 16'h0) begin
      errors++;
      $display("FAIL rstmid_outputs got %h want 0", {byte_out, byte_valid, sot, eot, sync_err, locked, bit_offset});
    end
    raw_valid = 1'b0;
    hs_en     = 1'b0;
    step();
    reset = 1'b0;
    repeat (3) step();
    checks++;
    if (eot_cnt != 0 || out_q.size() != 0) begin
      errors++;
      $display("FAIL rstmid_no_eot eot %0d bytes %0d want 0 0", eot_cnt, out_q.size());
    end
    stim_q = '{8'hB8, 8'h5A, 8'hC3, 8'h7E};
    model_run();
    run_burst(1'b0, 1'b0);
    checks++;
    if (out_q.size() != 2 || out_q[0] !== {1'b1, exp_q[0]}) begin
      errors++;
      $display("FAIL rstmid_rehunt bytes %0d first %h want 2 %h", out_q.size(), (out_q.size() > 0) ? out_q[0] : 9'h0, {1'b1, exp_q[0]});
    end
  endtask

  task automatic test_back_to_back();
    for (int b = 0; b < 10; b++) begin
      make_burst($urandom_range(1, 20));
      model_run();
      run_burst(1'($urandom), 1'($urandom));
      checks++;
      if (out_q.size() != exp_q.size()) begin
        errors++;
        $display("FAIL b2b%0d_count got %0d want %0d", b, out_q.size(), exp_q.size());
      end else begin
        foreach (exp_q[i]) begin
          logic [8:0] e;
          e = {(i == 0) ? 1'b1 : 1'b0, exp_q[i]};
          checks++;
          if (out_q[i] !== e) begin
            errors++;
            $display("FAIL b2b%0d_byte%0d got %h want %h", b, i, out_q[i], e);
          end
        end
      end
      checks++;
      if (eot_cnt != int'(m_found) || serr_cnt != int'(m_serr) || locked !== 1'b0) begin
        errors++;
        $display("FAIL b2b%0d_flags eot %0d serr %0d locked %b want %0d %0d 0", b, eot_cnt, serr_cnt, locked, m_found, m_serr);
      end
      if (m_found) begin
        checks++;
        if (bit_offset !== 3'(m_off)) begin
          errors++;
          $display("FAIL b2b%0d_offset got %0d want %0d", b, bit_offset, m_off);
        end
      end
`ifdef DPHY_RX_SOT_TOLERANT_EN
      checks++;
      if (soterr_cnt != int'(m_found && m_near)) begin
        errors++;
        $display("FAIL b2b%0d_soterr got %0d want %0d", b, soterr_cnt, int'(m_found && m_near));
      end
`endif
    end
  endtask

`ifdef DPHY_RX_SOT_TOLERANT_EN
  task automatic test_tolerant();
    clear_mon();
    hs_en = 1'b1;
    step();
    beat(8'hB9);
    beat(8'h12);
    checks++;
    if (locked !== 1'b1 || bit_offset !== 3'd0) begin
      errors++;
      $display("FAIL tol_lock locked %b off %0d want 1 0", locked, bit_offset);
    end
    beat(8'h34);
    hs_en = 1'b0;
    repeat (3) step();
    checks++;
    if (soterr_cnt != 1) begin
      errors++;
      $display("FAIL tol_soterr got %0d want 1", soterr_cnt);
    end
    checks++;
    if (out_q.size() != 1 || out_q[0] !== 9'h112) begin
      errors++;
      $display("FAIL tol_byte count %0d first %h want 1 112", out_q.size(), (out_q.size() > 0) ? out_q[0] : 9'h0);
    end
  endtask
`endif

  initial begin
    test_reset();
    test_offset0();
    test_offset3();
    test_timeout();
    test_eot_gaps();
    test_reset_mid();
    test_back_to_back();
`ifdef DPHY_RX_SOT_TOLERANT_EN
    test_tolerant();
`endif
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/dphy_rx_byte_align.md
# dphy_rx_byte_align

HS-mode byte aligner for one MIPI D-PHY receive data lane. It sits between the lane deserializer, which delivers unaligned 8-bit words in the byte-clock domain, and the CSI-2/DSI packet layer. It is the receive-side counterpart of the transmit clocking path.

- Searches each HS burst for the SoT sync byte at any of 8 bit offsets.
- Locks to the offset where the sync byte is found.
- Emits aligned payload bytes with SoT/EoT markers and a sync-timeout error.

## Interface
- `SYNC_BYTE`, default 8'hB8: SoT leader pattern, bit 0 first on the wire.
- `TIMEOUT`, default 16: raw beats allowed in HUNT before sync error; range 2..255.

Ports:
- `clk` in 1: byte clock.
- `reset` in 1: asynchronous, active-high reset.
- `hs_en` in 1: lane is in HS mode, from the LP detector; level signal.
- `raw_byte` in 8: deserialized word, bit 0 is the earliest received bit.
- `raw_valid` in 1: `raw_byte` is valid this cycle.
- `byte_out` out 8: aligned payload byte.
- `byte_valid` out 1: `byte_out` is valid.
- `sot` out 1: high together with the first payload byte of a burst.
- `eot` out 1: one-cycle pulse when a locked burst ends.
- `sync_err` out 1: one-cycle pulse on HUNT timeout.
- `locked` out 1: alignment is held.
- `bit_offset` out 3: latched offset.

## Operation
- Window: w[15:0] = {raw_byte, prev}.
  - prev is the `raw_byte` of the previous valid beat.
  - prev is cleared to 8'h00 in IDLE.
- Candidate k (k = 0..7) is w[k+7:k].
- States:
  - IDLE → HUNT when `hs_en` = 1.
  - HUNT: on each valid beat, test all 8 candidates against `SYNC_BYTE`.
    - If several match, the lowest k wins.
    - On a match: latch k into `bit_offset`, go to LOCKED. The sync byte itself is not emitted.
    - On no match: increment the beat counter. When the counter reaches `TIMEOUT`, pulse `sync_err` and go to FLUSH.
  - LOCKED: on each valid beat, emit w[off+7:off].
    - The first emitted byte carries `sot`.
  - FLUSH: discard beats until `hs_en` = 0, then go to IDLE.
- Leaving HS:
  - `hs_en` = 0 in any state → IDLE.
  - If the state was LOCKED, pulse `eot`.
  - Clear `locked` and the beat counter.
  - A `raw_valid` arriving in the same cycle that `hs_en` falls is dropped.
- `raw_valid` gaps are allowed in every state. prev and the counter advance only on valid beats.
- `bit_offset` holds its value after a burst until the next lock.

## Timing
- Reset values: `byte_out` = 0, `byte_valid` = 0, `sot` = 0, `eot` = 0, `sync_err` = 0, `locked` = 0, `bit_offset` = 0. State is IDLE, prev = 0, counter = 0.
- Latency:
  - Valid beat to `byte_valid`: 1 cycle, registered.
  - Sync-carrying beat to `locked` = 1: 1 cycle.
  - The beat after the sync beat produces the first `byte_valid` + `sot` one cycle later.
- `eot` and `sync_err` are registered and appear 1 cycle after their cause.
- The beat counter is 8 bits and saturates; it does not wrap.
- There is no backpressure: downstream must accept one byte per cycle.
- Reset mid-burst: all outputs return to reset values immediately. No `eot` is produced.

## Configuration
- `DPHY_RX_SOT_TOLERANT_EN`:
  - Defined: HUNT also accepts a candidate whose Hamming distance to `SYNC_BYTE` is exactly 1.
    - An exact match at any offset takes priority over a 1-bit match.
    - Otherwise the lowest k wins.
    - Adds output `sot_err` (1 bit), a registered pulse together with `locked` rising.
  - Undefined: exact match only. The `sot_err` port is absent.

## Structure
- Package `dphy_rx_pkg` holds:
  - the state enum (IDLE, HUNT, LOCKED, FLUSH);
  - the default `SYNC_BYTE` constant `DPHY_SYNC_BYTE` = 8'hB8;
  - the width constant for `bit_offset`.
- Sub-module `dphy_sync_match`: combinational 8-offset matcher.
  - Input: window.
  - Outputs: hit, offset, and, with the macro, the 1-bit-error hit.

## Test plan
- Offset 0: `hs_en` = 1; raw 8'hB8, 8'h55, 8'hAA.
  - `locked` = 1, `bit_offset` = 0.
  - `byte_out` 8'h55 with `sot`, then 8'hAA without `sot`.
- Offset 3: raw 8'hC0, 8'h05, then payload.
  - `bit_offset` = 3, `locked` = 1 after the 8'h05 beat.
  - Payload is emitted shifted by 3.
- Timeout: `hs_en` = 1 with 16 beats of 8'h00.
  - `sync_err` pulses once; no `byte_valid`.
  - FLUSH lasts until `hs_en` = 0.
- EoT with gaps: a locked burst with `raw_valid` toggling, then `hs_en` falls.
  - Exactly one byte per valid beat; `eot` pulses once; `locked` = 0.
- Reset mid-burst: `reset` asserted while LOCKED.
  - All outputs return to 0 immediately.
  - The next burst re-hunts, and `sot` reappears.
- With `DPHY_RX_SOT_TOLERANT_EN`: raw 8'hB9 (1-bit error) then 8'h12.
  - `locked` = 1 and `sot_err` pulses.
  - `byte_out` 8'h12 with `sot`.
